// File: rtl/mmio_io_port.sv
// mmio_io_port: memory-mapped LED / button peripheral on the processor data bus.
// Holds an LED register, synchronises and debounces the buttons, latches
// rising edges as sticky flags and raises a registered level interrupt.
//
// Bus handshake: wr_en and rd_en are single-cycle strobes with no back-pressure.
// A write takes effect at the clock edge that samples wr_en. A read sampled
// with rd_en at edge N returns rdata with rd_valid=1 after edge N+1, using the
// register contents from before any same-cycle write. rd_valid is low on every
// other cycle, and rdata then holds its last value.
module mmio_io_port #(
  parameter int LED_W     = 16,
  parameter int NBTN      = 5,
  parameter int DB_CYCLES = 4,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rd_valid,
  input  logic [NBTN-1:0]   btn,
  output logic [LED_W-1:0]  led,
  output logic              irq
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [ADDR_W-1:0] A_LED   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_SET   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CLR   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_LEVEL = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_EDGE  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_MASK  = ADDR_W'(5);

  logic [LED_W-1:0] led_q;
  logic [NBTN-1:0]  sync1_q, sync2_q;
  logic [NBTN-1:0]  level_q, level_nxt;
  logic [NBTN-1:0]  edge_q, edge_nxt;
  logic [NBTN-1:0]  mask_q;
  logic [NBTN-1:0]  rise;
  logic [CW-1:0]    cnt_q   [NBTN];
  logic [CW-1:0]    cnt_nxt [NBTN];
  logic [31:0]      rd_mux;
  logic             edge_w1c;

  // Upper wdata bits beyond the register widths have no destination.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  assign led      = led_q;
  assign edge_w1c = wr_en && (addr == A_EDGE);

  // LED register: plain write, bitwise set and bitwise clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q <= '0;
    end else if (wr_en) begin
      case (addr)
        A_LED:   led_q <= wdata[LED_W-1:0];
        A_SET:   led_q <= led_q | wdata[LED_W-1:0];
        A_CLR:   led_q <= led_q & ~wdata[LED_W-1:0];
        default: led_q <= led_q;
      endcase
    end
  end

  // Two-flop synchroniser for the raw asynchronous buttons.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a change is accepted after DB_CYCLES consecutive differing
  // samples; any sample matching the current level restarts the count.
  always_comb begin
    level_nxt = level_q;
    for (int i = 0; i < NBTN; i++) begin
      cnt_nxt[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_nxt[i] = sync2_q[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    rise = level_nxt & ~level_q;
    // A new rising edge beats a simultaneous write-one-to-clear.
    edge_nxt = edge_q;
    if (edge_w1c) begin
      edge_nxt = edge_q & ~wdata[NBTN-1:0];
    end
    edge_nxt = edge_nxt | rise;
  end

  // Debounce state, sticky edge flags, interrupt mask and interrupt register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
      irq     <= 1'b0;
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_nxt;
      edge_q  <= edge_nxt;
      irq     <= |(edge_q & mask_q);
      if (wr_en && (addr == A_MASK)) begin
        mask_q <= wdata[NBTN-1:0];
      end
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= cnt_nxt[i];
      end
    end
  end

  // Read mux over current register contents; unused upper bits read 0.
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_LED:   rd_mux[LED_W-1:0] = led_q;
      A_LEVEL: rd_mux[NBTN-1:0]  = level_q;
      A_EDGE:  rd_mux[NBTN-1:0]  = edge_q;
      A_MASK:  rd_mux[NBTN-1:0]  = mask_q;
      default: rd_mux = '0;
    endcase
  end

  // Registered read response, one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_port.sv
// Directed testbench for mmio_io_port with hand-computed expectations.
module tb_mmio_io_port;

  localparam int LED_W     = 16;
  localparam int NBTN      = 5;
  localparam int DB_CYCLES = 4;
  localparam int ADDR_W    = 3;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rd_valid;
  logic [NBTN-1:0]   btn;
  logic [LED_W-1:0]  led;
  logic              irq;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mmio_io_port #(
    .LED_W(LED_W), .NBTN(NBTN), .DB_CYCLES(DB_CYCLES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .btn(btn),
    .led(led), .irq(irq)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, settle 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, {31'b0, rd_valid}, 32'h1);
    check(tag, rdata, exp_q.pop_front());
    tick();
    check({tag, "_vlow"}, {31'b0, rd_valid}, 32'h0);
  endtask

  initial begin
    int ones;
    int first;
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = '0;
    wdata = '0;
    btn   = 5'h1F;

    // 1: reset with buttons held
    repeat (3) tick();
    check("rst_led", {16'b0, led}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rdv", {31'b0, rd_valid}, 32'h0);
    reset = 1'b1;
    rd_en = 1'b1;
    addr  = 3'd3;
    // level flips at edge 6 after release; streamed read shows it one edge later
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) check("rst_level_early", rdata, 32'h0);
      if (k == 7) check("rst_level_late", rdata, 32'h1F);
    end
    rd_en = 1'b0;
    tick();

    // 2: LED operations and register map boundaries
    bus_write(3'd0, 32'h0000_00F0);
    bus_write(3'd1, 32'h0000_0003);
    bus_write(3'd2, 32'h0000_0010);
    check("led_ops", {16'b0, led}, 32'h0000_00E3);
    bus_read("rd_led", 3'd0, 32'h0000_00E3);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_read("rd_led_upper", 3'd0, 32'h0000_FFFF);
    bus_write(3'd3, 32'h0000_0000);
    bus_read("rd_level_ro", 3'd3, 32'h0000_001F);
    bus_read("rd_unmapped", 3'd6, 32'h0000_0000);

    // 3: debounce against a bouncing button
    btn = 5'h00;
    repeat (8) tick();
    bus_write(3'd4, 32'h0000_001F);
    bus_read("edge_cleared", 3'd4, 32'h0);
    bus_read("level_zero", 3'd3, 32'h0);
    rd_en = 1'b1;
    addr  = 3'd3;
    ones  = 0;
    for (int c = 0; c < 20; c++) begin
      btn[0] = ((c / 2) % 2) == 0;
      tick();
      if (rdata[0]) ones++;
    end
    btn[0] = 1'b1;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (first == 0 && rdata[0]) first = k;
    end
    rd_en = 1'b0;
    tick();
    check("bounce_no_change", ones, 32'd0);
    check("bounce_latency", first, 32'd7);
    bus_read("bounce_edge", 3'd4, 32'h0000_0001);

    // 4: interrupt set, clear and masking
    bus_write(3'd4, 32'h1);
    btn = 5'h00;
    repeat (8) tick();
    bus_write(3'd5, 32'h1);
    check("irq_idle", {31'b0, irq}, 32'h0);
    btn[0] = 1'b1;
    repeat (6) tick();
    check("irq_before", {31'b0, irq}, 32'h0);
    tick();
    check("irq_set", {31'b0, irq}, 32'h1);
    bus_write(3'd4, 32'h1);
    check("irq_hold", {31'b0, irq}, 32'h1);
    tick();
    check("irq_clear", {31'b0, irq}, 32'h0);
    btn = 5'h03;
    repeat (8) tick();
    bus_read("edge_unmasked", 3'd4, 32'h0000_0002);
    check("irq_masked", {31'b0, irq}, 32'h0);
    bus_read("rd_mask", 3'd5, 32'h0000_0001);

    // 5: clear colliding with a new rising edge
    btn = 5'h02;
    repeat (8) tick();
    btn = 5'h03;
    repeat (5) tick();
    bus_write(3'd4, 32'h1);
    bus_read("edge_collision", 3'd4, 32'h0000_0003);

    // 6: read and write to the same address in one cycle
    bus_write(3'd0, 32'h0000_0055);
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr  = 3'd0;
    wdata = 32'h0000_00AA;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("rw_valid", {31'b0, rd_valid}, 32'h1);
    check("rw_old", rdata, 32'h0000_0055);
    check("rw_led", {16'b0, led}, 32'h0000_00AA);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
